axi4lite_reg_resp: RTL

//  AXI4-Lite responder: terminates one AXI4-Lite port (e.g. an outportN of the address distributor) and drives a simple req/ack register bus to a peripheral.

---
 rtl/axi4lite_pkg.sv | 26 ++
 rtl/axi4lite_reg_resp_if.sv | 37 +++
 rtl/axi4lite_chan_hold.sv | 58 +++++
 rtl/axi4lite_reg_resp.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/axi4lite_pkg.sv
// -----------------------------------------------------------------------------
// axi4lite_pkg
//   Shared definitions for the AXI4-Lite register responder:
//   - AXI response codes (OKAY / SLVERR)
//   - transaction FSM state encoding
//   - resp_of(): maps the peripheral error qualifier to an AXI response code
// Optional feature macro used by the responder: AXI4LITE_RESP_TIMEOUT_EN
// -----------------------------------------------------------------------------
package axi4lite_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR_REQ  = 3'd1,
    ST_RD_REQ  = 3'd2,
    ST_WR_RESP = 3'd3,
    ST_RD_RESP = 3'd4
  } state_t;

  function automatic logic [1:0] resp_of(input logic err);
    return err ? RESP_SLVERR : RESP_OKAY;
  endfunction

endpackage

// File: rtl/axi4lite_reg_resp_if.sv
// -----------------------------------------------------------------------------
// axi4lite_reg_resp_if
//   AXI4-Lite port bundle (AW, W, B, AR, R channels, 32-bit address/data).
//   modport master : drives requests (valid/addr/data/strb) and response readies
//   modport slave  : drives request readies and responses (B/R)
// -----------------------------------------------------------------------------
interface axi4lite_reg_resp_if;

  logic        awvalid;
  logic        awready;
  logic [31:0] awaddr;
  logic        wvalid;
  logic        wready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        bvalid;
  logic        bready;
  logic [1:0]  bresp;
  logic        arvalid;
  logic        arready;
  logic [31:0] araddr;
  logic        rvalid;
  logic        rready;
  logic [31:0] rdata;
  logic [1:0]  rresp;

  modport master (
    output awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
    input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );

  modport slave (
    input  awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
    output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );

endinterface

// File: rtl/axi4lite_chan_hold.sv
// -----------------------------------------------------------------------------
// axi4lite_chan_hold
//   Single-entry capture register for one AXI request channel (AW, W or AR).
//   Ports:
//     clk_i, rst_ni   clock / asynchronous active-low reset
//     valid_i,data_i  channel valid and payload from the master
//     open_i          the responder will be in IDLE next cycle
//     clear_i         release the entry (transaction completed)
//     ready_o         registered channel ready
//     full_o, data_o  entry occupied / captured payload
// -----------------------------------------------------------------------------
module axi4lite_chan_hold #(
  parameter int unsigned W = 32
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         valid_i,
  input  logic [W-1:0] data_i,
  input  logic         open_i,
  input  logic         clear_i,
  output logic         ready_o,
  output logic         full_o,
  output logic [W-1:0] data_o
);

  logic         ready_q;
  logic         full_q;
  logic         full_d;
  logic         take;
  logic [W-1:0] data_q;

  assign take = valid_i && ready_q;

  always_comb begin
    full_d = full_q;
    if (clear_i)   full_d = 1'b0;
    else if (take) full_d = 1'b1;
  end

  // Ready is computed from next-cycle state so it is a clean register output
  // and falls in the cycle right after the handshake.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ready_q <= 1'b0;
      full_q  <= 1'b0;
      data_q  <= '0;
    end else begin
      ready_q <= open_i && !full_d;
      full_q  <= full_d;
      if (take) data_q <= data_i;
    end
  end

  assign ready_o = ready_q;
  assign full_o  = full_q;
  assign data_o  = data_q;

endmodule

// File: rtl/axi4lite_reg_resp.sv
// -----------------------------------------------------------------------------
// axi4lite_reg_resp
//   AXI4-Lite responder: terminates one AXI4-Lite port and drives a simple
//   req/ack register bus. AW, W and AR are captured independently; one
//   transaction runs at a time; read/write arbitration alternates when both
//   are pending in the same cycle.
//   Ports:
//     clk_i, rst_ni      clock / asynchronous active-low reset
//     inport             AXI4-Lite slave port (axi4lite_reg_resp_if.slave)
//     reg_addr_o         register address (full AXI address)
//     reg_wdata_o/wstrb  register write data / byte strobes
//     reg_wr_o/reg_rd_o  write / read request, held until reg_ack_i
//     reg_rdata_i        read data, sampled with reg_ack_i
//     reg_ack_i          request complete
//     reg_err_i          error qualifier -> SLVERR
//   Parameter TIMEOUT_CYCLES: REQ-state cycles without ack before SLVERR.
//   Optional feature macro: AXI4LITE_RESP_TIMEOUT_EN (request timeout).
// -----------------------------------------------------------------------------
module axi4lite_reg_resp
  import axi4lite_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  axi4lite_reg_resp_if.slave   inport,
  output logic [31:0]          reg_addr_o,
  output logic [31:0]          reg_wdata_o,
  output logic [3:0]           reg_wstrb_o,
  output logic                 reg_wr_o,
  output logic                 reg_rd_o,
  input  logic [31:0]          reg_rdata_i,
  input  logic                 reg_ack_i,
  input  logic                 reg_err_i
);

  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be in 2..65535");
  end

  state_t      state_q, state_d;
  logic        prio_rd_q, prio_rd_d;
  logic        open;
  logic        clear_wr, clear_rd;
  logic        done;
  logic        timeout;

  logic        aw_full, w_full, ar_full;
  logic [31:0] aw_addr, ar_addr;
  logic [35:0] w_pay;

  logic        bvalid_q;
  logic [1:0]  bresp_q;
  logic        rvalid_q;
  logic [1:0]  rresp_q;
  logic [31:0] rdata_q;

  assign open = (state_d == ST_IDLE);

  axi4lite_chan_hold #(.W(32)) u_aw_hold (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .valid_i (inport.awvalid),
    .data_i  (inport.awaddr),
    .open_i  (open),
    .clear_i (clear_wr),
    .ready_o (inport.awready),
    .full_o  (aw_full),
    .data_o  (aw_addr)
  );

  axi4lite_chan_hold #(.W(36)) u_w_hold (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .valid_i (inport.wvalid),
    .data_i  ({inport.wstrb, inport.wdata}),
    .open_i  (open),
    .clear_i (clear_wr),
    .ready_o (inport.wready),
    .full_o  (w_full),
    .data_o  (w_pay)
  );

  axi4lite_chan_hold #(.W(32)) u_ar_hold (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .valid_i (inport.arvalid),
    .data_i  (inport.araddr),
    .open_i  (open),
    .clear_i (clear_rd),
    .ready_o (inport.arready),
    .full_o  (ar_full),
    .data_o  (ar_addr)
  );

`ifdef AXI4LITE_RESP_TIMEOUT_EN
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] to_cnt_q;
  logic        in_req;

  assign in_req  = (state_q == ST_WR_REQ) || (state_q == ST_RD_REQ);
  // Counter holds the number of REQ cycles already elapsed, so it reads
  // TO_LAST during the final permitted cycle.
  assign timeout = in_req && (to_cnt_q == TO_LAST) && !reg_ack_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)     to_cnt_q <= '0;
    else if (in_req) to_cnt_q <= to_cnt_q + 16'd1;
    else             to_cnt_q <= '0;
  end
`else
  assign timeout = 1'b0;
`endif

  assign done = reg_ack_i || timeout;

  always_comb begin
    state_d   = state_q;
    prio_rd_d = prio_rd_q;
    clear_wr  = 1'b0;
    clear_rd  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // The priority flag only moves when both sides actually compete.
        if (aw_full && w_full && ar_full) begin
          state_d   = prio_rd_q ? ST_RD_REQ : ST_WR_REQ;
          prio_rd_d = !prio_rd_q;
        end else if (aw_full && w_full) begin
          state_d = ST_WR_REQ;
        end else if (ar_full) begin
          state_d = ST_RD_REQ;
        end
      end
      ST_WR_REQ: begin
        if (done) begin
          state_d  = ST_WR_RESP;
          clear_wr = 1'b1;
        end
      end
      ST_RD_REQ: begin
        if (done) begin
          state_d  = ST_RD_RESP;
          clear_rd = 1'b1;
        end
      end
      ST_WR_RESP: if (inport.bready) state_d = ST_IDLE;
      ST_RD_RESP: if (inport.rready) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= ST_IDLE;
      prio_rd_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      prio_rd_q <= prio_rd_d;
    end
  end

  // Response registers: loaded on REQ completion, held until the handshake.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      bvalid_q <= 1'b0;
      bresp_q  <= RESP_OKAY;
      rvalid_q <= 1'b0;
      rresp_q  <= RESP_OKAY;
      rdata_q  <= '0;
    end else begin
      if (state_q == ST_WR_REQ && done) begin
        bvalid_q <= 1'b1;
        bresp_q  <= reg_ack_i ? resp_of(reg_err_i) : RESP_SLVERR;
      end else if (state_q == ST_WR_RESP && inport.bready) begin
        bvalid_q <= 1'b0;
      end
      if (state_q == ST_RD_REQ && done) begin
        rvalid_q <= 1'b1;
        rresp_q  <= reg_ack_i ? resp_of(reg_err_i) : RESP_SLVERR;
        rdata_q  <= reg_ack_i ? reg_rdata_i : 32'h0;
      end else if (state_q == ST_RD_RESP && inport.rready) begin
        rvalid_q <= 1'b0;
      end
    end
  end

  assign inport.bvalid = bvalid_q;
  assign inport.bresp  = bresp_q;
  assign inport.rvalid = rvalid_q;
  assign inport.rresp  = rresp_q;
  assign inport.rdata  = rdata_q;

  assign reg_wr_o    = (state_q == ST_WR_REQ);
  assign reg_rd_o    = (state_q == ST_RD_REQ);
  assign reg_addr_o  = reg_wr_o ? aw_addr : (reg_rd_o ? ar_addr : 32'h0);
  assign reg_wdata_o = reg_wr_o ? w_pay[31:0]  : 32'h0;
  assign reg_wstrb_o = reg_wr_o ? w_pay[35:32] : 4'h0;

endmodule
